instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Program-counter / call-stack sequencer for a combinational program ROM.
//   The instruction returned for oIP is decoded in the same cycle and the
//   next address is registered on the following rising edge (no fetch bubble).
//
// Parameters
//   STACK_DEPTH     number of return-address entries (power of two, 2..16)
//
// Ports
//   Clock           single clock, rising edge
//   Reset           synchronous, active-high; overrides every other input
//   iInstruction    [27:0] ROM word at oIP: [27:24] opcode, [23:16] target
//   iBranchTaken    compare result for the current BLE (1 = branch)
//   iStall          freezes oIP, the stack, the depth and the flags
//   oIP             [15:0] instruction pointer to the ROM address input
//   oStackDepth     [4:0] number of valid return entries
//   oStackOverflow  sticky: CALL issued with a full stack
//   oStackUnderflow sticky: RET issued with an empty stack
//   oHalted         high while either error flag is set

`ifndef NOP
`define NOP  4'h0
`endif
`ifndef JMP
`define JMP  4'h1
`endif
`ifndef CALL
`define CALL 4'h2
`endif
`ifndef RET
`define RET  4'h3
`endif
`ifndef BLE
`define BLE  4'h4
`endif

module instruction_sequencer #(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [27:0] iInstruction,
  input  logic        iBranchTaken,
  input  logic        iStall,
  output logic [15:0] oIP,
  output logic [4:0]  oStackDepth,
  output logic        oStackOverflow,
  output logic        oStackUnderflow,
  output logic        oHalted
);

  localparam int unsigned AW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_MAX = 5'(STACK_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  logic [15:0] stack [STACK_DEPTH];

  logic [3:0]    opcode;
  logic [15:0]   target;
  logic [15:0]   ip_inc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          advance;

  logic [15:0] nxt_ip;
  logic        push;
  logic        pop;
  logic        ovf_evt;
  logic        unf_evt;

  // Operand field bits below the target are not used by the sequencer.
  logic unused_low_bits;
  assign unused_low_bits = ^iInstruction[15:0];

  assign opcode = iInstruction[27:24];
  assign target = {8'd0, iInstruction[23:16]};
  assign ip_inc = oIP + 16'd1;          // wraps 16'hFFFF -> 16'h0000

  // The depth counter doubles as the stack pointer: entry [depth] is the
  // next free slot and [depth-1] is the top. At full depth the low bits
  // wrap to 0, so depth-1 computed in AW bits still points at the top.
  assign wr_idx = oStackDepth[AW-1:0];
  assign rd_idx = oStackDepth[AW-1:0] - AW'(1);

  // A stall or a halt freezes everything; reset is handled ahead of this.
  assign advance = !iStall && (state == RUN);

  always_comb begin
    nxt_ip  = ip_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (opcode)
      `JMP: begin
        nxt_ip = target;
      end
      `CALL: begin
        if (oStackDepth < DEPTH_MAX) begin
          push   = 1'b1;
          nxt_ip = target;
        end else begin
          ovf_evt = 1'b1;
          nxt_ip  = oIP;
        end
      end
      `RET: begin
        if (oStackDepth != 5'd0) begin
          pop    = 1'b1;
          nxt_ip = stack[rd_idx];
        end else begin
          unf_evt = 1'b1;
          nxt_ip  = oIP;
        end
      end
      `BLE: begin
        nxt_ip = iBranchTaken ? target : ip_inc;
      end
      default: begin
        nxt_ip = ip_inc;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= RUN;
      oIP             <= '0;
      oStackDepth     <= '0;
      oStackOverflow  <= 1'b0;
      oStackUnderflow <= 1'b0;
      oHalted         <= 1'b0;
    end else if (advance) begin
      oIP <= nxt_ip;
      if (push) begin
        oStackDepth <= oStackDepth + 5'd1;
      end else if (pop) begin
        oStackDepth <= oStackDepth - 5'd1;
      end
      if (ovf_evt || unf_evt) begin
        state           <= HALT;
        oHalted         <= 1'b1;
        oStackOverflow  <= oStackOverflow  | ovf_evt;
        oStackUnderflow <= oStackUnderflow | unf_evt;
      end
    end
  end

  // Stack contents need no reset; only the depth defines which are valid.
  always_ff @(posedge Clock) begin
    if (!Reset && advance && push) begin
      stack[wr_idx] <= ip_inc;
    end
  end

endmodule
